// File: rtl/fb_pkg.sv
// ============================================================================
//  Module   : fb_pkg
//  Brief    : Framebuffer geometry, buffer base addresses and the queued
//             pixel entry type, shared by the write queue and the GPU clip
//             compare.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam int          FB_WIDTH  = 400;
    localparam int          FB_HEIGHT = 240;
    localparam int          COLOR_W   = 16;
    localparam int          OFFSET_W  = $clog2(FB_WIDTH * FB_HEIGHT);

    // Buffer 1 sits directly after buffer 0 (16-bit pixels, 2 bytes each).
    localparam logic [31:0] BASE0     = 32'h0000_0000;
    localparam logic [31:0] BASE1     = BASE0 + 32'(FB_WIDTH * FB_HEIGHT * 2);

    // One queued pixel: linear pixel offset inside a buffer plus its color.
    typedef struct packed {
        logic [OFFSET_W-1:0] offset;
        logic [COLOR_W-1:0]  color;
    } pixel_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock first-word-fall-through FIFO with occupancy count.
//             Head data reads as zero while the FIFO is empty.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; a push into a full FIFO alongside a pop reuses the slot
    // being vacated, whose old contents were already presented this cycle.
    always_ff @(posedge clk) begin
        if (i_push) begin
            mem_q[wr_ptr_q] <= i_din;
        end
    end

    assign o_dout  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/fb_write_queue.sv
// ============================================================================
//  Module   : fb_write_queue
//  Brief    : Bounds-checks GPU pixel writes, maps them to back-buffer byte
//             addresses, queues them and drains them to the framebuffer
//             memory port. Owns the double-buffer select; a swap request
//             takes effect only once every queued pixel has drained.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_queue #(
    parameter int          FB_WIDTH   = fb_pkg::FB_WIDTH,
    parameter int          FB_HEIGHT  = fb_pkg::FB_HEIGHT,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE0      = fb_pkg::BASE0,
    parameter logic [31:0] BASE1      = fb_pkg::BASE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] fb_x,
    input  logic [15:0] fb_y,
    input  logic [15:0] fb_color,
    input  logic        fb_write,
    output logic        almost_full,
    output logic        overflow,
    input  logic        overflow_clear,
    input  logic        swap_req,
    output logic        front_buffer,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_write,
    input  logic        mem_ready
);

    import fb_pkg::*;

    localparam int          OFF_W    = $clog2(FB_WIDTH * FB_HEIGHT);
    localparam int          ENTRY_W  = OFF_W + COLOR_W;
    localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] WIDTH_U  = 32'(FB_WIDTH);
    localparam logic [31:0] HEIGHT_U = 32'(FB_HEIGHT);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_PENDING = 1'b1;

    typedef struct packed {
        logic [OFF_W-1:0]   offset;
        logic [COLOR_W-1:0] color;
    } entry_t;

    entry_t           push_entry;
    entry_t           head_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             in_bounds;
    logic             pop;
    logic             push_ok;
    logic             swap_edge;

    logic [0:0]       state_q, state_d;
    logic             front_buffer_q, front_buffer_d;
    logic             overflow_q, overflow_d;
    logic             swap_req_q, swap_req_d;

    // Bounds check and linear offset of the incoming pixel. The offset is
    // formed modulo 2**OFF_W: any in-bounds pixel's offset is below
    // FB_WIDTH*FB_HEIGHT <= 2**OFF_W, so the modular result is exact and no
    // wider intermediate is needed.
    always_comb begin
        in_bounds         = fb_write && (32'(fb_x) < WIDTH_U) && (32'(fb_y) < HEIGHT_U);
        push_entry.offset = OFF_W'(fb_y) * OFF_W'(FB_WIDTH) + OFF_W'(fb_x);
        push_entry.color  = fb_color;
    end

    // Handshake and acceptance: a full queue still takes a pixel when the head leaves on the same edge.
    always_comb begin
        mem_write = (fifo_count != '0);
        pop       = mem_write && mem_ready;
        push_ok   = in_bounds && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (push_ok),
        .i_pop   (pop),
        .i_din   (push_entry),
        .o_dout  (head_entry),
        .o_count (fifo_count)
    );

    // Memory port and status outputs, all from registered state. The head
    // reads as zero when empty, so an idle port shows the back-buffer base.
    always_comb begin
        mem_addr     = (front_buffer_q ? BASE0 : BASE1) + 32'({head_entry.offset, 1'b0});
        mem_wdata    = head_entry.color;
        almost_full  = (fifo_count >= CNT_W'(FIFO_DEPTH - 2));
        busy         = mem_write || (state_q == ST_PENDING);
        front_buffer = front_buffer_q;
        overflow     = overflow_q;
    end

    // Sticky overflow (a dropped in-bounds pixel beats a same-edge clear) and swap edge capture.
    always_comb begin
        overflow_d = overflow_q;
        if (in_bounds && !push_ok) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end
        swap_req_d = swap_req;
        swap_edge  = swap_req && !swap_req_q;
    end

    // Swap FSM: hold the request until the queue is empty and nothing new is entering it.
    always_comb begin
        state_d        = state_q;
        front_buffer_d = front_buffer_q;
        case (state_q)
            ST_IDLE: begin
                if (swap_edge) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (!mem_write && !push_ok) begin
                    front_buffer_d = !front_buffer_q;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            front_buffer_q <= 1'b0;
            overflow_q     <= 1'b0;
            swap_req_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            front_buffer_q <= front_buffer_d;
            overflow_q     <= overflow_d;
            swap_req_q     <= swap_req_d;
        end
    end

endmodule

`default_nettype wire
